// File: rtl/multicycle_control.sv
// Multicycle RV32-subset control FSM: datapath strobes per state, retired count, sticky traps.
// Latency B/J 3, S and LUI/I 4, L 5 cycles; stalls in FETCH/MEM while mem_ready is low (watchdog traps).
module multicycle_control #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_read,
    output logic               mem_write,
    output logic               sb,
    output logic               ir_write,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] aluop,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               pc_write,
    output logic               pc_sel,
    output logic [2:0]         state,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_I   = 7'b0010011;

    localparam int              WCW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0]  WLIM = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]     next_state;
    logic [1:0]     next_cause;
    logic [6:0]     op_q;
    logic [2:0]     f3_q;
    logic [WCW-1:0] wcnt;
    logic           timeout_hit;
    logic           op_legal;

    assign timeout_hit = (TIMEOUT > 0) && (wcnt == WLIM) && !mem_ready;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LUI, OP_JAL, OP_B, OP_L, OP_S, OP_I: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            op_q       <= '0;
            f3_q       <= '0;
            wcnt       <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
            retired    <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                op_q <= opcode;
                f3_q <= funct3;
            end
            if (next_state != state)
                wcnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !mem_ready)
                wcnt <= wcnt + 1'b1;
            if (next_state == S_TRAP && state != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= next_cause;
            end
            if (pc_write)
                retired <= retired + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = 2'b00;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = 2'b11;
                end
            end
            S_DECODE: begin
                if (!op_legal) begin
                    next_state = S_TRAP;
                    next_cause = 2'b01;
                end else if (opcode == OP_S && funct3 != 3'b000 && funct3 != 3'b010) begin
                    next_state = S_TRAP;
                    next_cause = 2'b10;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_B, OP_JAL: next_state = S_FETCH;
                    OP_L, OP_S:   next_state = S_MEM;
                    default:      next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    next_state = (op_q == OP_L) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                    next_cause = 2'b11;
                end
            end
            S_WB:    next_state = S_FETCH;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

    // Reset gates every strobe so nothing toggles while it is held.
    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        sb         = 1'b0;
        ir_write   = 1'b0;
        alu_src    = 1'b0;
        aluop      = '0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                end
                S_EXEC: begin
                    alu_src = (op_q != OP_B);
                    case (op_q)
                        OP_B: begin
                            aluop    = ALUOP_W'(1);
                            pc_write = 1'b1;
                            pc_sel   = zero;
                        end
                        OP_JAL: begin
                            aluop    = ALUOP_W'(0);
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                        end
                        OP_L:    aluop = ALUOP_W'(2);
                        OP_S:    aluop = ALUOP_W'(3);
                        OP_I:    aluop = ALUOP_W'(4);
                        default: aluop = ALUOP_W'(0);
                    endcase
                end
                S_MEM: begin
                    alu_src = 1'b1;
                    mem_req = 1'b1;
                    if (op_q == OP_L) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        sb        = (f3_q == 3'b000);
                        pc_write  = mem_ready;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_L);
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed literal checks plus randomized episodes
// compared every cycle against a phase-list model of each instruction.
module tb_multicycle_control;

    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALI = 7'b0010011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_read, mem_write, sb, ir_write, alu_src;
    logic [2:0] aluop;
    logic       reg_write, mem_to_reg, pc_write, pc_sel;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] retired;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    multicycle_control #(.ALUOP_W(3), .CNT_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read),
        .mem_write(mem_write), .sb(sb), .ir_write(ir_write), .alu_src(alu_src),
        .aluop(aluop), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_sel(pc_sel), .state(state), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Instruction classes: 0 LUI, 1 JAL, 2 B, 3 L, 4 S, 5 I-ALU, -1 illegal.
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            LUI: return 0;
            JAL: return 1;
            BR:  return 2;
            LW:  return 3;
            ST:  return 4;
            ALI: return 5;
            default: return -1;
        endcase
    endfunction

    int alu_tab[6] = '{0, 0, 1, 2, 3, 4};

    // Model: current phase plus the list of phases left in this instruction.
    int m_ph = 0, m_cls = 0, m_f3 = 0, m_wait = 0, m_cause = 0, m_ret = 0;
    int m_q[$];

    always @(negedge clk) begin
        bit e_req, e_rd, e_wr, e_sb, e_ir, e_src, e_rw, e_m2r, e_pcw, e_pcs;
        bit [2:0] e_alu;
        logic [12:0] exp_s, act_s;
        logic [9:0]  exp_t, act_t;
        int nph, c;
        if (chk_en) begin
            {e_req, e_rd, e_wr, e_sb, e_ir, e_src, e_rw, e_m2r, e_pcw, e_pcs} = '0;
            e_alu = '0;
            if (reset) begin
                m_ph = 0; m_cls = 0; m_f3 = 0; m_wait = 0; m_cause = 0; m_ret = 0;
                m_q.delete();
            end else begin
                case (m_ph)
                    0: begin e_req = 1; e_rd = 1; e_ir = mem_ready; end
                    2: begin
                        e_alu = 3'(alu_tab[m_cls]);
                        e_src = (m_cls != 2);
                        if (m_cls == 2) begin e_pcw = 1; e_pcs = zero; end
                        if (m_cls == 1) begin e_pcw = 1; e_pcs = 1; end
                    end
                    3: begin
                        e_src = 1; e_req = 1;
                        e_rd  = (m_cls == 3);
                        e_wr  = (m_cls == 4);
                        e_sb  = (m_cls == 4) && (m_f3 == 0);
                        e_pcw = (m_cls == 4) && mem_ready;
                    end
                    4: begin e_rw = 1; e_m2r = (m_cls == 3); e_pcw = 1; end
                    default: ;
                endcase
            end
            exp_s = {e_req, e_rd, e_wr, e_sb, e_ir, e_src, e_alu, e_rw, e_m2r, e_pcw, e_pcs};
            act_s = {mem_req, mem_read, mem_write, sb, ir_write, alu_src, aluop,
                     reg_write, mem_to_reg, pc_write, pc_sel};
            exp_t = {3'(m_ph), m_cause != 0, 2'(m_cause), 4'(m_ret)};
            act_t = {state, trap, trap_cause, retired};
            checks += 2;
            if (act_s !== exp_s) begin
                failures++;
                $display("FAIL strobes at %0t: got %b expected %b", $time, act_s, exp_s);
            end
            if (act_t !== exp_t) begin
                failures++;
                $display("FAIL status at %0t: got %b expected %b", $time, act_t, exp_t);
            end
            if (!reset) begin
                nph = m_ph;
                case (m_ph)
                    0, 3: begin
                        if (mem_ready) nph = (m_ph == 0) ? 1 : ((m_q.size() > 0) ? m_q.pop_front() : 0);
                        else if (m_wait == 15) begin nph = 7; m_cause = 3; end
                    end
                    1: begin
                        c = cls_of(opcode);
                        if (c < 0) begin nph = 7; m_cause = 1; end
                        else if (c == 4 && funct3 != 0 && funct3 != 2) begin nph = 7; m_cause = 2; end
                        else begin
                            m_cls = c; m_f3 = funct3; nph = 2;
                            m_q.delete();
                            if (c == 3) m_q = '{3, 4};
                            else if (c == 4) m_q = '{3};
                            else if (c == 0 || c == 5) m_q = '{4};
                        end
                    end
                    2, 4: nph = (m_q.size() > 0) ? m_q.pop_front() : 0;
                    default: ;
                endcase
                if (e_pcw) m_ret = (m_ret + 1) % 16;
                if (nph != m_ph) m_wait = 0;
                else if ((m_ph == 0 || m_ph == 3) && !mem_ready) m_wait++;
                m_ph = nph;
            end
        end
    end

    task automatic setin(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic r);
        opcode = op; funct3 = f3; zero = z; mem_ready = r;
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    initial begin
        int r, mode;
        chk_en = 1'b1;
        do_reset();

        // ADDI with immediate memory: 0,1,2,4,0
        setin(ALI, 3'b000, 0, 1);
        check("rst_state", state, 0);
        check("rst_fetch_req", {mem_req, mem_read, mem_write}, 3'b110);
        check("rst_retired", retired, 0);
        check("rst_trap", {trap, trap_cause}, 0);
        nxt(); check("addi_decode", state, 1);
        nxt(); check("addi_exec", {state, aluop, alu_src}, {3'd2, 3'b100, 1'b1});
        nxt(); check("addi_wb", {state, reg_write, mem_to_reg, pc_write, pc_sel}, {3'd4, 4'b1010});
        nxt(); check("addi_done", {state, retired}, {3'd0, 4'd1});

        // LW with three wait cycles in MEM
        do_reset();
        setin(LW, 3'b010, 0, 1);
        nxt(); nxt();
        check("lw_exec", {state, aluop}, {3'd2, 3'b010});
        setin(LW, 3'b010, 0, 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            check("lw_mem_hold", {state, mem_req, mem_read, mem_write}, {3'd3, 3'b110});
        end
        setin(LW, 3'b010, 0, 1);
        nxt(); check("lw_wb", {state, reg_write, mem_to_reg}, {3'd4, 2'b11});

        // SB, SW, bad store funct3
        do_reset();
        setin(ST, 3'b000, 0, 1);
        nxt(); nxt(); check("sb_exec", {state, aluop, alu_src}, {3'd2, 3'b011, 1'b1});
        nxt(); check("sb_mem", {state, mem_write, sb, pc_write, pc_sel}, {3'd3, 4'b1110});
        nxt(); check("sb_done", {state, retired}, {3'd0, 4'd1});
        setin(ST, 3'b010, 0, 1);
        nxt(); nxt(); nxt(); check("sw_mem", {state, mem_write, sb}, {3'd3, 2'b10});
        do_reset();
        setin(ST, 3'b001, 0, 1);
        nxt(); nxt(); check("st_bad_f3", {state, trap, trap_cause}, {3'd7, 1'b1, 2'b10});

        // BEQ taken then not taken, 3 cycles each
        do_reset();
        setin(BR, 3'b000, 1, 1);
        nxt(); nxt(); check("beq_taken", {state, pc_write, pc_sel, alu_src}, {3'd2, 3'b110});
        setin(BR, 3'b000, 0, 1);
        nxt(); check("beq_3cyc", {state, retired}, {3'd0, 4'd1});
        nxt(); nxt(); check("beq_not_taken", {state, pc_write, pc_sel}, {3'd2, 2'b10});

        // Illegal opcode traps and stays quiet
        do_reset();
        setin(7'b0110011, 3'b000, 0, 1);
        nxt(); nxt(); check("illegal_trap", {state, trap, trap_cause}, {3'd7, 1'b1, 2'b01});
        for (int i = 0; i < 20; i++) begin
            setin(ALI, 3'(i), i[0], i[1]);
            nxt();
        end
        check("trap_quiet", {mem_req, mem_read, mem_write, ir_write, reg_write, pc_write, trap_cause},
              {6'b0, 2'b01});

        // Watchdog: ready on the last allowed cycle wins, otherwise trap after 16
        do_reset();
        repeat (15) nxt();
        check("wd_not_early", {state, trap}, {3'd0, 1'b0});
        setin(ALI, 3'b000, 0, 1);
        nxt(); check("wd_ready_wins", {state, trap}, {3'd1, 1'b0});
        do_reset();
        repeat (16) nxt();
        check("wd_timeout", {state, trap, trap_cause, mem_req}, {3'd7, 1'b1, 2'b11, 1'b0});

        // Reset during MEM of SW drops strobes at once
        do_reset();
        setin(ALI, 3'b000, 0, 1);
        repeat (4) nxt();
        setin(ST, 3'b010, 0, 1);
        nxt(); nxt();
        setin(ST, 3'b010, 0, 0);
        nxt(); check("sw_pre_reset", {state, mem_write, retired}, {3'd3, 1'b1, 4'd1});
        reset = 1'b1;
        #1;
        check("sw_reset_async", {state, mem_write, mem_req, retired}, {3'd0, 1'b0, 1'b0, 4'd0});

        // Retired counter wraps at CNT_W=4
        do_reset();
        setin(JAL, 3'b000, 0, 1);
        repeat (45) nxt();
        check("ret_15", retired, 15);
        repeat (3) nxt();
        check("ret_wrap", retired, 0);

        // Randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            mode = ep % 3;
            do_reset();
            for (int cyc = 0; cyc < 300; cyc++) begin
                r = $urandom_range(0, 99);
                if (mode == 1 && r < 4) opcode = 7'($urandom);
                else begin
                    case ($urandom_range(0, 5))
                        0: opcode = LUI;
                        1: opcode = JAL;
                        2: opcode = BR;
                        3: opcode = LW;
                        4: opcode = ST;
                        default: opcode = ALI;
                    endcase
                end
                r = $urandom_range(0, 99);
                funct3 = (r < 45) ? 3'b000 : (r < 90) ? 3'b010 : 3'($urandom);
                zero = 1'($urandom);
                mem_ready = (mode == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
                nxt();
                if ($urandom_range(0, 399) == 0) do_reset();
            end
        end

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
